// File: rtl/sda_kernel_gmem_arbiter.sv
// rtl/sda_kernel_gmem_arbiter.sv - two-requester AXI4 arbiter onto one gmem master port
//
// Purpose: merges two kernel AXI4 requesters (s0, s1) onto a single m_axi_gmem
// master. Read and write address channels are arbitrated independently with
// round-robin priority; responses are routed back by ID (ID == requester index).
// Writes are serialised: one AW plus its full W burst must finish before the
// next AW is accepted, so W never needs reordering.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   sN_ar* / sN_arready      requester read address (N = 0, 1)
//   sN_r*  / sN_rready       requester read data
//   sN_aw* / sN_awready      requester write address
//   sN_w*  / sN_wready       requester write data
//   sN_b*  / sN_bready       requester write response
//   m_axi_gmem_*             AXI4 master bundle (1-bit IDs)
//   rd_busy, wr_busy         read / write traffic in flight
module sda_kernel_gmem_arbiter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    // requester 0
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [7:0]              s0_awlen,
    input  logic [2:0]              s0_awsize,
    input  logic [1:0]              s0_awburst,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wlast,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    // requester 1
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [7:0]              s1_awlen,
    input  logic [2:0]              s1_awsize,
    input  logic [1:0]              s1_awburst,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wlast,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic [1:0]              s1_bresp,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    // master AR
    output logic                    m_axi_gmem_ARID,
    output logic [ADDR_WIDTH-1:0]   m_axi_gmem_ARADDR,
    output logic [7:0]              m_axi_gmem_ARLEN,
    output logic [2:0]              m_axi_gmem_ARSIZE,
    output logic [1:0]              m_axi_gmem_ARBURST,
    output logic                    m_axi_gmem_ARLOCK,
    output logic [3:0]              m_axi_gmem_ARCACHE,
    output logic [2:0]              m_axi_gmem_ARPROT,
    output logic [3:0]              m_axi_gmem_ARQOS,
    output logic [3:0]              m_axi_gmem_ARREGION,
    output logic                    m_axi_gmem_ARUSER,
    output logic                    m_axi_gmem_ARVALID,
    input  logic                    m_axi_gmem_ARREADY,
    // master R
    input  logic                    m_axi_gmem_RID,
    input  logic [DATA_WIDTH-1:0]   m_axi_gmem_RDATA,
    input  logic [1:0]              m_axi_gmem_RRESP,
    input  logic                    m_axi_gmem_RLAST,
    input  logic                    m_axi_gmem_RVALID,
    output logic                    m_axi_gmem_RREADY,
    // master AW
    output logic                    m_axi_gmem_AWID,
    output logic [ADDR_WIDTH-1:0]   m_axi_gmem_AWADDR,
    output logic [7:0]              m_axi_gmem_AWLEN,
    output logic [2:0]              m_axi_gmem_AWSIZE,
    output logic [1:0]              m_axi_gmem_AWBURST,
    output logic                    m_axi_gmem_AWLOCK,
    output logic [3:0]              m_axi_gmem_AWCACHE,
    output logic [2:0]              m_axi_gmem_AWPROT,
    output logic [3:0]              m_axi_gmem_AWQOS,
    output logic [3:0]              m_axi_gmem_AWREGION,
    output logic                    m_axi_gmem_AWUSER,
    output logic                    m_axi_gmem_AWVALID,
    input  logic                    m_axi_gmem_AWREADY,
    // master W
    output logic                    m_axi_gmem_WID,
    output logic [DATA_WIDTH-1:0]   m_axi_gmem_WDATA,
    output logic [DATA_WIDTH/8-1:0] m_axi_gmem_WSTRB,
    output logic                    m_axi_gmem_WLAST,
    output logic                    m_axi_gmem_WUSER,
    output logic                    m_axi_gmem_WVALID,
    input  logic                    m_axi_gmem_WREADY,
    // master B
    input  logic                    m_axi_gmem_BID,
    input  logic [1:0]              m_axi_gmem_BRESP,
    input  logic                    m_axi_gmem_BVALID,
    output logic                    m_axi_gmem_BREADY,
    // status
    output logic                    rd_busy,
    output logic                    wr_busy
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic { AR_IDLE, AR_HOLD } ar_state_t;
    typedef enum logic { W_IDLE,  W_BUSY  } w_state_t;

    // ------------------------------------------------------------------
    // Read address arbitration
    // ------------------------------------------------------------------
    ar_state_t             r_ar_state, w_ar_state_nxt;
    logic                  r_ar_prio;      // requester that wins a tie
    logic [CW-1:0]         r_rd_count;
    logic                  r_ar_id;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;

    logic w_ar_grant;
    logic w_ar_win;
    logic w_ar_hs;
    logic w_r_done;

    assign w_ar_win = (s0_arvalid && s1_arvalid) ? r_ar_prio : s1_arvalid;
    assign w_ar_hs  = (r_ar_state == AR_HOLD) && m_axi_gmem_ARREADY;
    assign w_r_done = m_axi_gmem_RVALID && m_axi_gmem_RREADY && m_axi_gmem_RLAST;

    always_comb begin
        w_ar_state_nxt = r_ar_state;
        w_ar_grant     = 1'b0;
        case (r_ar_state)
            AR_IDLE: begin
                if (!reset && (s0_arvalid || s1_arvalid) && (r_rd_count < MAX_CNT)) begin
                    w_ar_grant     = 1'b1;
                    w_ar_state_nxt = AR_HOLD;
                end
            end
            AR_HOLD: begin
                if (m_axi_gmem_ARREADY) begin
                    w_ar_state_nxt = AR_IDLE;
                end
            end
            default: w_ar_state_nxt = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar_state <= AR_IDLE;
        end else begin
            r_ar_state <= w_ar_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar_prio  <= 1'b0;
            r_ar_id    <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
        end else if (w_ar_grant) begin
            r_ar_prio  <= ~w_ar_win;
            r_ar_id    <= w_ar_win;
            r_ar_addr  <= w_ar_win ? s1_araddr  : s0_araddr;
            r_ar_len   <= w_ar_win ? s1_arlen   : s0_arlen;
            r_ar_size  <= w_ar_win ? s1_arsize  : s0_arsize;
            r_ar_burst <= w_ar_win ? s1_arburst : s0_arburst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
        end else if (w_ar_hs && !w_r_done) begin
            r_rd_count <= r_rd_count + 1'b1;
        end else if (!w_ar_hs && w_r_done) begin
            r_rd_count <= r_rd_count - 1'b1;
        end
    end

    assign s0_arready          = w_ar_grant && !w_ar_win;
    assign s1_arready          = w_ar_grant &&  w_ar_win;
    assign m_axi_gmem_ARVALID  = (r_ar_state == AR_HOLD);
    assign m_axi_gmem_ARID     = r_ar_id;
    assign m_axi_gmem_ARADDR   = r_ar_addr;
    assign m_axi_gmem_ARLEN    = r_ar_len;
    assign m_axi_gmem_ARSIZE   = r_ar_size;
    assign m_axi_gmem_ARBURST  = r_ar_burst;
    assign m_axi_gmem_ARLOCK   = 1'b0;
    assign m_axi_gmem_ARCACHE  = 4'b0011;
    assign m_axi_gmem_ARPROT   = 3'b000;
    assign m_axi_gmem_ARQOS    = 4'd0;
    assign m_axi_gmem_ARREGION = 4'd0;
    assign m_axi_gmem_ARUSER   = 1'b0;

    // Read data: steered back purely by RID, no buffering.
    assign s0_rvalid         = m_axi_gmem_RVALID && !m_axi_gmem_RID;
    assign s1_rvalid         = m_axi_gmem_RVALID &&  m_axi_gmem_RID;
    assign m_axi_gmem_RREADY = m_axi_gmem_RID ? s1_rready : s0_rready;
    assign s0_rdata          = m_axi_gmem_RDATA;
    assign s1_rdata          = m_axi_gmem_RDATA;
    assign s0_rresp          = m_axi_gmem_RRESP;
    assign s1_rresp          = m_axi_gmem_RRESP;
    assign s0_rlast          = m_axi_gmem_RLAST;
    assign s1_rlast          = m_axi_gmem_RLAST;

    assign rd_busy = (r_rd_count != '0) || (r_ar_state == AR_HOLD);

    // ------------------------------------------------------------------
    // Write arbitration: AW and its W burst are owned by one requester
    // until both have completed, in either order.
    // ------------------------------------------------------------------
    w_state_t              r_w_state, w_w_state_nxt;
    logic                  r_aw_prio;
    logic                  r_w_owner;
    logic                  r_aw_pend;
    logic                  r_w_pend;
    logic [CW-1:0]         r_wr_count;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [7:0]            r_aw_len;
    logic [2:0]            r_aw_size;
    logic [1:0]            r_aw_burst;

    logic w_aw_grant;
    logic w_aw_win;
    logic w_aw_hs;
    logic w_wlast_hs;
    logic w_b_done;

    assign w_aw_win   = (s0_awvalid && s1_awvalid) ? r_aw_prio : s1_awvalid;
    assign w_aw_hs    = r_aw_pend && m_axi_gmem_AWREADY;
    assign w_wlast_hs = m_axi_gmem_WVALID && m_axi_gmem_WREADY && m_axi_gmem_WLAST;
    assign w_b_done   = m_axi_gmem_BVALID && m_axi_gmem_BREADY;

    always_comb begin
        w_w_state_nxt = r_w_state;
        w_aw_grant    = 1'b0;
        case (r_w_state)
            W_IDLE: begin
                if (!reset && (s0_awvalid || s1_awvalid) && (r_wr_count < MAX_CNT)) begin
                    w_aw_grant    = 1'b1;
                    w_w_state_nxt = W_BUSY;
                end
            end
            W_BUSY: begin
                // Leave as soon as the last outstanding half completes.
                if (!(r_aw_pend && !w_aw_hs) && !(r_w_pend && !w_wlast_hs)) begin
                    w_w_state_nxt = W_IDLE;
                end
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_state <= W_IDLE;
        end else begin
            r_w_state <= w_w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_prio  <= 1'b0;
            r_w_owner  <= 1'b0;
            r_aw_pend  <= 1'b0;
            r_w_pend   <= 1'b0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
        end else if (w_aw_grant) begin
            r_aw_prio  <= ~w_aw_win;
            r_w_owner  <= w_aw_win;
            r_aw_pend  <= 1'b1;
            r_w_pend   <= 1'b1;
            r_aw_addr  <= w_aw_win ? s1_awaddr  : s0_awaddr;
            r_aw_len   <= w_aw_win ? s1_awlen   : s0_awlen;
            r_aw_size  <= w_aw_win ? s1_awsize  : s0_awsize;
            r_aw_burst <= w_aw_win ? s1_awburst : s0_awburst;
        end else begin
            if (w_aw_hs) begin
                r_aw_pend <= 1'b0;
            end
            if (w_wlast_hs) begin
                r_w_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if (w_aw_hs && !w_b_done) begin
            r_wr_count <= r_wr_count + 1'b1;
        end else if (!w_aw_hs && w_b_done) begin
            r_wr_count <= r_wr_count - 1'b1;
        end
    end

    assign s0_awready          = w_aw_grant && !w_aw_win;
    assign s1_awready          = w_aw_grant &&  w_aw_win;
    assign m_axi_gmem_AWVALID  = r_aw_pend;
    assign m_axi_gmem_AWID     = r_w_owner;
    assign m_axi_gmem_AWADDR   = r_aw_addr;
    assign m_axi_gmem_AWLEN    = r_aw_len;
    assign m_axi_gmem_AWSIZE   = r_aw_size;
    assign m_axi_gmem_AWBURST  = r_aw_burst;
    assign m_axi_gmem_AWLOCK   = 1'b0;
    assign m_axi_gmem_AWCACHE  = 4'b0011;
    assign m_axi_gmem_AWPROT   = 3'b000;
    assign m_axi_gmem_AWQOS    = 4'd0;
    assign m_axi_gmem_AWREGION = 4'd0;
    assign m_axi_gmem_AWUSER   = 1'b0;

    assign m_axi_gmem_WVALID = r_w_pend && (r_w_owner ? s1_wvalid : s0_wvalid);
    assign m_axi_gmem_WDATA  = r_w_owner ? s1_wdata : s0_wdata;
    assign m_axi_gmem_WSTRB  = r_w_owner ? s1_wstrb : s0_wstrb;
    assign m_axi_gmem_WLAST  = r_w_owner ? s1_wlast : s0_wlast;
    assign m_axi_gmem_WID    = r_w_owner;
    assign m_axi_gmem_WUSER  = 1'b0;
    assign s0_wready         = r_w_pend && !r_w_owner && m_axi_gmem_WREADY;
    assign s1_wready         = r_w_pend &&  r_w_owner && m_axi_gmem_WREADY;

    assign s0_bvalid         = m_axi_gmem_BVALID && !m_axi_gmem_BID;
    assign s1_bvalid         = m_axi_gmem_BVALID &&  m_axi_gmem_BID;
    assign m_axi_gmem_BREADY = m_axi_gmem_BID ? s1_bready : s0_bready;
    assign s0_bresp          = m_axi_gmem_BRESP;
    assign s1_bresp          = m_axi_gmem_BRESP;

    assign wr_busy = (r_wr_count != '0) || (r_w_state == W_BUSY);

endmodule

// File: tb/tb_sda_kernel_gmem_arbiter.sv
// tb/tb_sda_kernel_gmem_arbiter.sv - self-checking bench for sda_kernel_gmem_arbiter
module tb_sda_kernel_gmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [63:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr;
    logic [7:0]  s0_arlen, s1_arlen, s0_awlen, s1_awlen;
    logic [2:0]  s0_arsize, s1_arsize, s0_awsize, s1_awsize;
    logic [1:0]  s0_arburst, s1_arburst, s0_awburst, s1_awburst;
    logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [63:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
    logic        s0_awvalid, s1_awvalid, s0_awready, s1_awready;
    logic [63:0] s0_wdata, s1_wdata;
    logic [7:0]  s0_wstrb, s1_wstrb;
    logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
    logic [1:0]  s0_bresp, s1_bresp;
    logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;

    logic        ARID, ARLOCK, ARUSER, ARVALID, ARREADY;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE, ARPROT;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE, ARQOS, ARREGION;
    logic        RID, RLAST, RVALID, RREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        AWID, AWLOCK, AWUSER, AWVALID, AWREADY;
    logic [63:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE, AWPROT;
    logic [1:0]  AWBURST;
    logic [3:0]  AWCACHE, AWQOS, AWREGION;
    logic        WID, WLAST, WUSER, WVALID, WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        BID, BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        rd_busy, wr_busy;

    sda_kernel_gmem_arbiter dut (
        .clk(clk), .reset(reset),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .m_axi_gmem_ARID(ARID), .m_axi_gmem_ARADDR(ARADDR), .m_axi_gmem_ARLEN(ARLEN),
        .m_axi_gmem_ARSIZE(ARSIZE), .m_axi_gmem_ARBURST(ARBURST), .m_axi_gmem_ARLOCK(ARLOCK),
        .m_axi_gmem_ARCACHE(ARCACHE), .m_axi_gmem_ARPROT(ARPROT), .m_axi_gmem_ARQOS(ARQOS),
        .m_axi_gmem_ARREGION(ARREGION), .m_axi_gmem_ARUSER(ARUSER),
        .m_axi_gmem_ARVALID(ARVALID), .m_axi_gmem_ARREADY(ARREADY),
        .m_axi_gmem_RID(RID), .m_axi_gmem_RDATA(RDATA), .m_axi_gmem_RRESP(RRESP),
        .m_axi_gmem_RLAST(RLAST), .m_axi_gmem_RVALID(RVALID), .m_axi_gmem_RREADY(RREADY),
        .m_axi_gmem_AWID(AWID), .m_axi_gmem_AWADDR(AWADDR), .m_axi_gmem_AWLEN(AWLEN),
        .m_axi_gmem_AWSIZE(AWSIZE), .m_axi_gmem_AWBURST(AWBURST), .m_axi_gmem_AWLOCK(AWLOCK),
        .m_axi_gmem_AWCACHE(AWCACHE), .m_axi_gmem_AWPROT(AWPROT), .m_axi_gmem_AWQOS(AWQOS),
        .m_axi_gmem_AWREGION(AWREGION), .m_axi_gmem_AWUSER(AWUSER),
        .m_axi_gmem_AWVALID(AWVALID), .m_axi_gmem_AWREADY(AWREADY),
        .m_axi_gmem_WID(WID), .m_axi_gmem_WDATA(WDATA), .m_axi_gmem_WSTRB(WSTRB),
        .m_axi_gmem_WLAST(WLAST), .m_axi_gmem_WUSER(WUSER),
        .m_axi_gmem_WVALID(WVALID), .m_axi_gmem_WREADY(WREADY),
        .m_axi_gmem_BID(BID), .m_axi_gmem_BRESP(BRESP), .m_axi_gmem_BVALID(BVALID), .m_axi_gmem_BREADY(BREADY),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard for the master AR channel: pushed when a requester is granted,
    // popped when the master handshake is seen.
    typedef struct { logic id; logic [63:0] addr; logic [7:0] len; } ar_exp_t;
    ar_exp_t ar_q[$];

    always @(negedge clk) begin
        #2;
        if (ARVALID && ARREADY) begin
            if (ar_q.size() == 0) begin
                chk("ar_unexpected", 64'd1, 64'd0);
            end else begin
                ar_exp_t e;
                e = ar_q.pop_front();
                chk("ar_id", ARID, e.id);
                chk("ar_addr", ARADDR, e.addr);
                chk("ar_len", ARLEN, e.len);
                chk("ar_cache", ARCACHE, 64'h3);
            end
        end
    end

    // Response routing vectors, shared by the R and B channel tables.
    typedef struct {
        logic v; logic id; logic last; logic rdy0; logic rdy1; logic [63:0] data;
        logic e0; logic e1; logic erdy;
    } vec_t;

    vec_t rtab[7];
    vec_t btab[4];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // vectors: RID = 1,0,1 beats, ready-follows-RID cases, then two RLASTs
        rtab[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h11, 1'b0, 1'b1, 1'b1};
        rtab[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h22, 1'b1, 1'b0, 1'b1};
        rtab[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h33, 1'b0, 1'b1, 1'b0};
        rtab[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h44, 1'b1, 1'b0, 1'b0};
        rtab[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h55, 1'b0, 1'b0, 1'b1};
        rtab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h66, 1'b0, 1'b1, 1'b1};
        rtab[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h77, 1'b1, 1'b0, 1'b1};
        // data field carries BRESP; only the last vector completes a handshake
        btab[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0};
        btab[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2, 1'b0, 1'b1, 1'b0};
        btab[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h3, 1'b0, 1'b0, 1'b1};
        btab[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        s0_araddr = '0; s1_araddr = '0; s0_awaddr = '0; s1_awaddr = '0;
        s0_arlen = '0; s1_arlen = '0; s0_awlen = '0; s1_awlen = '0;
        s0_arsize = 3'd3; s1_arsize = 3'd3; s0_awsize = 3'd3; s1_awsize = 3'd3;
        s0_arburst = 2'd1; s1_arburst = 2'd1; s0_awburst = 2'd1; s1_awburst = 2'd1;
        s0_arvalid = 0; s1_arvalid = 0; s0_rready = 0; s1_rready = 0;
        s0_awvalid = 0; s1_awvalid = 0;
        s0_wdata = '0; s1_wdata = '0; s0_wstrb = '0; s1_wstrb = '0;
        s0_wlast = 0; s1_wlast = 0; s0_wvalid = 0; s1_wvalid = 0;
        s0_bready = 0; s1_bready = 0;
        ARREADY = 0; RID = 0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
        AWREADY = 0; WREADY = 0; BID = 0; BRESP = '0; BVALID = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_wr_busy", wr_busy, 0);

        // both requesters request a read together: s0 first, then s1
        @(negedge clk);
        s0_arvalid = 1; s0_araddr = 64'hA0; s0_arlen = 8'd3;
        s1_arvalid = 1; s1_araddr = 64'hA1; s1_arlen = 8'd5;
        #1;
        chk("rr_s0_arready", s0_arready, 1);
        chk("rr_s1_arready", s1_arready, 0);
        ar_q.push_back('{1'b0, 64'hA0, 8'd3});
        @(negedge clk);
        s0_arvalid = 0; ARREADY = 1;
        #1;
        chk("hold_arvalid", ARVALID, 1);
        chk("hold_s1_arready", s1_arready, 0);
        @(negedge clk);
        #1;
        chk("rr_s1_arready_2", s1_arready, 1);
        ar_q.push_back('{1'b1, 64'hA1, 8'd5});
        @(negedge clk);
        s1_arvalid = 0;
        @(negedge clk);
        ARREADY = 0;
        #1;
        chk("rd_busy_2out", rd_busy, 1);

        // R routing table; the two RLAST beats retire both reads
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            RVALID = rtab[i].v; RID = rtab[i].id; RLAST = rtab[i].last;
            RDATA = rtab[i].data; s0_rready = rtab[i].rdy0; s1_rready = rtab[i].rdy1;
            #1;
            chk($sformatf("r%0d_s0_rvalid", i), s0_rvalid, rtab[i].e0);
            chk($sformatf("r%0d_s1_rvalid", i), s1_rvalid, rtab[i].e1);
            chk($sformatf("r%0d_rready", i), RREADY, rtab[i].erdy);
            chk($sformatf("r%0d_rdata", i), rtab[i].id ? s1_rdata : s0_rdata, rtab[i].data);
        end
        @(negedge clk);
        RVALID = 0; RLAST = 0; s0_rready = 0; s1_rready = 0;
        #1;
        chk("rd_busy_drained", rd_busy, 0);

        // fill the outstanding-read limit from s0
        ARREADY = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s0_arvalid = 1; s0_araddr = 64'(i) * 64'h100; s0_arlen = 8'd0;
            #1;
            chk($sformatf("fill%0d_arready", i), s0_arready, 1);
            ar_q.push_back('{1'b0, 64'(i) * 64'h100, 8'd0});
            @(negedge clk);
            s0_arvalid = 0;
        end
        @(negedge clk);
        s0_arvalid = 1; s0_araddr = 64'h900;
        #1;
        chk("full_arready", s0_arready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("full_stall%0d", i), s0_arready, 0);
        end
        @(negedge clk);
        RVALID = 1; RID = 0; RLAST = 1; s0_rready = 1;
        #1;
        chk("full_rlast_cycle", s0_arready, 0);
        @(negedge clk);
        RVALID = 0;
        #1;
        chk("full_reassert", s0_arready, 1);
        ar_q.push_back('{1'b0, 64'h900, 8'd0});
        @(negedge clk);
        s0_arvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            RVALID = 1; RID = 0; RLAST = 1; s0_rready = 1;
        end
        @(negedge clk);
        RVALID = 0; RLAST = 0; s0_rready = 0; ARREADY = 0;
        #1;
        chk("rd_busy_after_fill", rd_busy, 0);

        // s1 write: W burst finishes while AW is held off by the master
        @(negedge clk);
        s1_awvalid = 1; s1_awaddr = 64'hB100; s1_awlen = 8'd3; WREADY = 1;
        #1;
        chk("w_s1_awready", s1_awready, 1);
        chk("w_s0_awready_idle", s0_awready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s1_awvalid = 0;
            s0_awvalid = 1; s0_awaddr = 64'hA000; s0_awlen = 8'd3;
            s0_wvalid = 1; s0_wdata = 64'hDEAD;
            s1_wvalid = 1; s1_wdata = 64'h1000 + 64'(k); s1_wstrb = 8'(k + 1); s1_wlast = (k == 3);
            #1;
            chk($sformatf("w%0d_wvalid", k), WVALID, 1);
            chk($sformatf("w%0d_wdata", k), WDATA, 64'h1000 + 64'(k));
            chk($sformatf("w%0d_wstrb", k), WSTRB, 64'(k + 1));
            chk($sformatf("w%0d_wid", k), WID, 1);
            chk($sformatf("w%0d_s1_wready", k), s1_wready, 1);
            chk($sformatf("w%0d_s0_wready", k), s0_wready, 0);
            chk($sformatf("w%0d_s0_awready", k), s0_awready, 0);
            chk($sformatf("w%0d_awvalid", k), AWVALID, 1);
        end
        chk("w_awid", AWID, 1);
        chk("w_awaddr", AWADDR, 64'hB100);
        @(negedge clk);
        s1_wvalid = 0; s1_wlast = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("wait%0d_wvalid", i), WVALID, 0);
            chk($sformatf("wait%0d_s0_awready", i), s0_awready, 0);
            chk($sformatf("wait%0d_wr_busy", i), wr_busy, 1);
            @(negedge clk);
        end
        AWREADY = 1;
        #1;
        chk("aw_hs_awvalid", AWVALID, 1);
        chk("aw_hs_s0_awready", s0_awready, 0);
        @(negedge clk);
        AWREADY = 0;
        #1;
        chk("back_idle_s0_awready", s0_awready, 1);
        @(negedge clk);
        s0_awvalid = 0;
        #1;
        chk("s0_awvalid_m", AWVALID, 1);
        chk("s0_awid", AWID, 0);
        chk("s0_awaddr", AWADDR, 64'hA000);

        // B routing table; last vector retires the s1 write
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            BVALID = btab[i].v; BID = btab[i].id; BRESP = btab[i].data[1:0];
            s0_bready = btab[i].rdy0; s1_bready = btab[i].rdy1;
            #1;
            chk($sformatf("b%0d_s0_bvalid", i), s0_bvalid, btab[i].e0);
            chk($sformatf("b%0d_s1_bvalid", i), s1_bvalid, btab[i].e1);
            chk($sformatf("b%0d_bready", i), BREADY, btab[i].erdy);
            chk($sformatf("b%0d_bresp", i), btab[i].id ? s1_bresp : s0_bresp, btab[i].data);
        end
        @(negedge clk);
        BVALID = 0; s0_bready = 0; s1_bready = 0;
        #1;
        chk("wr_busy_s0_owned", wr_busy, 1);

        // s0 W beats 0,1 then reset during beat 2
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            s0_wvalid = 1; s0_wdata = 64'hC0 + 64'(j); s0_wlast = 0;
            #1;
            chk($sformatf("s0w%0d_wdata", j), WDATA, 64'hC0 + 64'(j));
            chk($sformatf("s0w%0d_wready", j), s0_wready, 1);
            chk($sformatf("s0w%0d_s1_wready", j), s1_wready, 0);
        end
        @(negedge clk);
        s0_wdata = 64'hC2; reset = 1;
        @(negedge clk);
        reset = 0; s0_wvalid = 0;
        #1;
        chk("mid_rst_awvalid", AWVALID, 0);
        chk("mid_rst_wvalid", WVALID, 0);
        chk("mid_rst_arvalid", ARVALID, 0);
        chk("mid_rst_s0_wready", s0_wready, 0);
        chk("mid_rst_wr_busy", wr_busy, 0);
        chk("mid_rst_rd_busy", rd_busy, 0);

        // both pointers back at s0 after reset
        @(negedge clk);
        s0_arvalid = 1; s0_araddr = 64'hE0; s0_arlen = 8'd1;
        s1_arvalid = 1; s1_araddr = 64'hE1;
        s0_awvalid = 1; s1_awvalid = 1; ARREADY = 1;
        #1;
        chk("post_rst_s0_arready", s0_arready, 1);
        chk("post_rst_s1_arready", s1_arready, 0);
        chk("post_rst_s0_awready", s0_awready, 1);
        chk("post_rst_s1_awready", s1_awready, 0);
        ar_q.push_back('{1'b0, 64'hE0, 8'd1});
        @(negedge clk);
        s0_arvalid = 0; s1_arvalid = 0; s0_awvalid = 0; s1_awvalid = 0;
        @(negedge clk);
        ARREADY = 0;
        #1;
        chk("ar_queue_empty", 64'(ar_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sda_kernel_gmem_arbiter.md
SDA_KERNEL_GMEM_ARBITER -- requirements
Module: sda_kernel_gmem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 64, AXI address width.
- DATA_WIDTH, default 64, AXI data width.
- MAX_OUTSTANDING, default 8, maximum accepted-but-incomplete bursts per direction.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset. Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- sN_ar{addr,len,size,burst,valid}/sN_arready  N=0,1  ADDR_WIDTH/8/3/2/1/1 (arready out)  requester read address.
- sN_r{data,resp,last,valid}/sN_rready  N=0,1  DATA_WIDTH/2/1/1/1 (rready in)  requester read data.
- sN_aw{addr,len,size,burst,valid}/sN_awready  N=0,1  as AR  requester write address.
- sN_w{data,strb,last,valid}/sN_wready  N=0,1  DATA_WIDTH/DATA_WIDTH/8/1/1/1  requester write data.
- sN_b{resp,valid}/sN_bready  N=0,1  2/1/1  requester write response.
- m_axi_gmem_* AR, R, AW, W, B  master bundle, AXI4 naming  ARID/AWID/RID/BID 1 bit.
- rd_busy, wr_busy  out  1  outstanding read / write bursts non-zero.

Function
REQ-003 AR arbitration SHALL use states AR_IDLE and AR_HOLD.
REQ-004 In AR_IDLE with any sN_arvalid and rd_count<MAX_OUTSTANDING, the winner's sN_arready SHALL be 1 for one cycle and its fields captured; next cycle m ARVALID=1 with ARID=N (AR_HOLD).
REQ-005 Winner SHALL be round-robin: when both are valid, the requester not granted last wins; rr pointer after reset selects s0.
REQ-006 In AR_HOLD, m ARVALID and all AR fields SHALL remain stable until ARREADY; on handshake return to AR_IDLE, rd_count+1.
REQ-007 sN_arready SHALL be 0 in AR_HOLD, and when rd_count==MAX_OUTSTANDING.
REQ-008 R SHALL route combinationally by RID: sN_rvalid = RVALID & (RID==N); RREADY = s[RID]_rready; data/resp/last pass through.
REQ-009 rd_count SHALL decrement on each R handshake with RLAST=1; simultaneous increment and decrement SHALL leave it unchanged.
REQ-010 Write arbitration SHALL use states W_IDLE and W_BUSY with flags aw_pend and w_pend and an owner register.
REQ-011 In W_IDLE with any sN_awvalid and wr_count<MAX_OUTSTANDING, the same round-robin rule on a separate pointer SHALL accept the winner's AW, set owner=N, aw_pend=w_pend=1, and enter W_BUSY.
REQ-012 In W_BUSY, m AWVALID SHALL equal aw_pend with AWID=owner; AW handshake SHALL clear aw_pend and increment wr_count.
REQ-013 While w_pend=1, W SHALL pass through from owner only (WVALID, WDATA, WSTRB, WLAST; s_owner_wready=WREADY); the non-owner's wready SHALL be 0.
REQ-014 A W handshake with WLAST=1 SHALL clear w_pend; W may complete before AW.
REQ-015 When both aw_pend and w_pend are clear, the block SHALL return to W_IDLE; no new AW is accepted before then.
REQ-016 B SHALL route by BID as in REQ-008; wr_count SHALL decrement on B handshake, with simultaneous inc/dec unchanged.
REQ-017 ARLOCK/AWLOCK, CACHE (0011), PROT (000), QOS, REGION and USER SHALL be constant; WID SHALL equal owner.
REQ-018 rd_busy SHALL equal (rd_count!=0 | state==AR_HOLD); wr_busy SHALL equal (wr_count!=0 | state==W_BUSY).

Reset
REQ-019 Reset SHALL force AR_IDLE, W_IDLE, counts 0, aw_pend=w_pend=0, owner=0, both rr pointers to s0, and all valid/ready outputs 0. Reset mid-burst SHALL discard state without completing the transaction.

Verification
REQ-020 s0 and s1 both arvalid in the same cycle from reset -> s0 granted, ARID=0 one cycle later; s1 granted next, ARID=1.
REQ-021 Eight AR bursts accepted with no R returned -> ninth arvalid stalls with arready=0; one RLAST handshake -> arready reasserts the next cycle.
REQ-022 Interleaved R beats with RID=1,0,1 -> only the matching sN_rvalid is asserted each beat, and RREADY follows that requester's rready.
REQ-023 s1 AW len=3, AWREADY held low for 10 cycles while s1 sends 4 W beats -> W completes first, state stays W_BUSY until AW handshake, then W_IDLE; s0 awvalid is not accepted meanwhile.
REQ-024 Reset asserted during W beat 2 of a burst -> all outputs 0 the next cycle, wr_busy=0, and s0 wins the first subsequent arbitration.
